interrupt_sequencer: RTL

//  CPU-side end of the interrupt handshake. Consumes int_cpu/int_id from the interrupt controller.

---
 rtl/cpu_int_pkg.sv | 14 +
 rtl/interrupt_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/cpu_int_pkg.sv
// Constants shared by the interrupt controller and the CPU-side interrupt sequencer:
// the FSM encoding, the default ISR vector and the interrupt ID width.
package cpu_int_pkg;

  localparam int INT_ID_W        = 8;
  localparam int INT_VECTOR_ADDR = 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ENTER  = 3'd2;
  localparam logic [2:0] S_ISR    = 3'd3;
  localparam logic [2:0] S_RETURN = 3'd4;

endpackage

// File: rtl/interrupt_sequencer.sv
// CPU-side interrupt handshake: accepts a request, waits for a safe boundary, redirects fetch
// to the vector, and on reti redirects back to the saved resume PC.
module interrupt_sequencer
  import cpu_int_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ID_W        = INT_ID_W,
  parameter int VECTOR_ADDR = INT_VECTOR_ADDR,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              int_cpu,
  input  logic [ID_W-1:0]   int_id,
  output logic              int_disabled,
  input  logic              safe_point,
  input  logic [ADDR_W-1:0] pc_resume,
  input  logic              reti_valid,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              flush,
  output logic              in_isr,
  output logic [ID_W-1:0]   cause_id,
  output logic [ADDR_W-1:0] epc,
  output logic              reti_err,
  output logic [CNT_W-1:0]  int_count
);

  localparam logic [ADDR_W-1:0] VECTOR_PC = ADDR_W'(VECTOR_ADDR);

  logic [2:0]        r_state;
  logic              r_int_disabled;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic [ID_W-1:0]   r_cause_id;
  logic [ADDR_W-1:0] r_epc;
  logic              r_reti_err;
  logic [CNT_W-1:0]  r_int_count;

  // NOTE: every register here is written with <= so all of them update from the same
  // pre-edge values; a blocking assignment would leak new values into later statements.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_int_disabled   <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_cause_id       <= '0;
      r_epc            <= '0;
      r_reti_err       <= 1'b0;
      r_int_count      <= '0;
    end else begin
      r_reti_err <= reti_valid && (r_state != S_ISR);
      case (r_state)
        S_IDLE: begin
          if (int_cpu) begin
            r_cause_id     <= int_id;
            r_int_disabled <= 1'b1;
            if (r_int_count != {CNT_W{1'b1}}) r_int_count <= r_int_count + CNT_W'(1);
            r_state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (safe_point) begin
            r_epc            <= pc_resume;
            r_redirect_pc    <= VECTOR_PC;
            r_redirect_valid <= 1'b1;
            r_state          <= S_ENTER;
          end
        end
        S_ENTER: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_state          <= S_ISR;
          end
        end
        S_ISR: begin
          // reti takes priority; a concurrent int_cpu is simply not looked at here.
          if (reti_valid) begin
            r_redirect_pc    <= r_epc;
            r_redirect_valid <= 1'b1;
            r_state          <= S_RETURN;
          end
        end
        S_RETURN: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_int_disabled   <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: flush and in_isr are pure continuous decodes of registers, so no latch can form.
  assign flush          = r_redirect_valid && (r_state == S_ENTER);
  assign in_isr         = (r_state == S_ISR) || (r_state == S_RETURN);
  assign int_disabled   = r_int_disabled;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign cause_id       = r_cause_id;
  assign epc            = r_epc;
  assign reti_err       = r_reti_err;
  assign int_count      = r_int_count;

endmodule
